// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: the FSM state enum, the port-id
// enum, the default memory latency and a helper that sizes the wait counter.
package mem_arb_pkg;

  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  // Width needed to hold MEM_LATENCY-1 (at least one bit).
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Wait counter for the memory arbiter: loadable down-counter with a
// terminal-count (zero) flag. Saturates at zero.
// Ports:
//   clk, rst_b   clock, synchronous active-low reset
//   load         load count with load_val (takes priority over dec)
//   dec          decrement by one
//   load_val     value to load
//   count        current count
//   zero         count == 0
module arb_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port (read-only) and a data
// port share one memory with a fixed access latency of MEM_LATENCY cycles.
// One transaction at a time: IDLE grants, ACCESS waits out the latency and
// captures read data, RESP pulses the granted port's done for one cycle.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests (data port first after reset). Default build: data port always
// wins simultaneous requests.
//
// Ports:
//   clk, rst_b                      clock, synchronous active-low reset
//   i_req, i_addr                   fetch request / byte address
//   i_rdata, i_done                 fetched word, completion pulse
//   d_req, d_we, d_addr, d_wdata    data request / write flag / address / wdata
//   d_rdata, d_done                 data read word, completion pulse
//   mem_addr, mem_wdata             shared memory address / write word
//   mem_write_en                    shared memory write strobe
//   mem_rdata                       shared memory read word
//   busy                            high whenever not IDLE
//
// state  | meaning
// IDLE   | waiting for a request; grants one port and loads the wait counter
// ACCESS | memory cycle in progress; counter runs down, read data captured at 0
// RESP   | one-cycle done pulse to the granted port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int             CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t       state, state_nxt;
  port_id_t         grant_q, grant_sel;
  logic [31:0]      addr_q, wdata_q;
  logic             we_q;
  logic             cnt_load, cnt_dec, cnt_zero, capture;
  logic [CNT_W-1:0] cnt;

`ifdef ARB_ROUND_ROBIN_EN
  port_id_t         last_q;
`endif

  arb_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_LOAD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    grant_sel = PORT_I;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant_sel = (last_q == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      grant_sel = PORT_D;
    end
`else
    if (d_req) begin
      grant_sel = PORT_D;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    capture      = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt = ACCESS;
          cnt_load  = 1'b1;
        end
      end
      ACCESS: begin
        // The counter still holds its load value only in the first cycle,
        // so the write strobe lasts exactly one cycle.
        if ((cnt == CNT_LOAD) && (grant_q == PORT_D) && we_q) begin
          mem_write_en = 1'b1;
        end
        if (cnt_zero) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        i_done    = (grant_q == PORT_I);
        d_done    = (grant_q == PORT_D);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      grant_q <= PORT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= PORT_I;
`endif
    end else begin
      if (cnt_load) begin
        grant_q <= grant_sel;
`ifdef ARB_ROUND_ROBIN_EN
        last_q  <= grant_sel;
`endif
        if (grant_sel == PORT_D) begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end else begin
          // Fetch is read-only: never carry a write flag or write data.
          addr_q  <= i_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end
      if (capture && !we_q) begin
        if (grant_q == PORT_D) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int          LAT  = 4;
  localparam logic [31:0] MUL  = 32'h9E37_79B1;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_done, d_done, mem_write_en, busy;

  logic        i_req1, d_req1, d_we1;
  logic [31:0] i_addr1, d_addr1, d_wdata1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        i_done1, d_done1, mem_write_en1, busy1;

  logic        mem_const_en;
  logic [31:0] mem_const;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          g;
    int          done;
  } txn_t;

  txn_t        q[$];
  int          m_idle_at = 0;
  int          m_last_g = 0;
  logic [31:0] m_i_rd = '0;
  logic [31:0] m_d_rd = '0;
  logic [31:0] m_addr_shown = '0;
  int          we_cnt = 0;
  logic [31:0] we_addr_seen = '0;
  logic [31:0] we_wdata_seen = '0;
`ifdef ARB_ROUND_ROBIN_EN
  logic        m_last = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data depends on address and on the cycle it is sampled.
  assign mem_rdata  = mem_const_en ? mem_const : ((mem_addr * MUL) ^ 32'(cyc));
  assign mem_rdata1 = 32'hCAFE_0001;

  mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_write_en(mem_write_en1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input int c);
    if (mem_const_en) return mem_const;
    return (a * MUL) ^ 32'(c);
  endfunction

  // Transaction-level reference: one transaction at a time, each occupying
  // LAT+1 cycles after the cycle in which it was granted.
  function automatic void model_step();
    txn_t t;
    logic gd;
    if (!rst_b) begin
      q.delete();
      m_idle_at    = cyc + 1;
      m_i_rd       = '0;
      m_d_rd       = '0;
      m_addr_shown = '0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last       = 1'b0;
`endif
      return;
    end
    if ((cyc >= m_idle_at) && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i_req && d_req) gd = !m_last;
      else                gd = d_req;
      m_last = gd;
`else
      gd = d_req;
`endif
      t.is_d  = gd;
      t.we    = gd ? d_we : 1'b0;
      t.addr  = gd ? d_addr : i_addr;
      t.wdata = gd ? d_wdata : 32'h0;
      t.g     = cyc;
      t.done  = cyc + LAT + 1;
      q.push_back(t);
      m_idle_at = cyc + LAT + 2;
      m_last_g  = cyc;
    end
  endfunction

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  // which: 0 fetch, 1 data, 2 either. got: 0 fetch, 1 data, -1 none.
  task automatic wait_done(input int which, output int got);
    int n;
    n   = 0;
    got = -1;
    do begin
      tick();
      n++;
    end while (!(((which != 1) && i_done) || ((which != 0) && d_done)) && (n < 40));
    if (i_done)      got = 0;
    else if (d_done) got = 1;
    chk("done_arrived", {31'b0, (got >= 0)}, 32'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    txn_t f;
    logic eb, ew, eid, edd;
    eb = 1'b0; ew = 1'b0; eid = 1'b0; edd = 1'b0;
    f  = '{default: '0};
    if (q.size() > 0) begin
      f = q[0];
      if (f.g < cyc) begin
        eb = 1'b1;
        m_addr_shown = f.addr;
        if (f.is_d && f.we && (cyc == f.g + 1)) ew = 1'b1;
      end
      if (f.done == cyc) begin
        eid = !f.is_d;
        edd = f.is_d;
        if (!f.we) begin
          if (f.is_d) m_d_rd = exp_rd(f.addr, cyc - 1);
          else        m_i_rd = exp_rd(f.addr, cyc - 1);
        end
      end
    end
    chk("busy", {31'b0, busy}, {31'b0, eb});
    chk("i_done", {31'b0, i_done}, {31'b0, eid});
    chk("d_done", {31'b0, d_done}, {31'b0, edd});
    chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, ew});
    chk("mem_addr", mem_addr, m_addr_shown);
    if (ew) chk("mem_wdata", mem_wdata, f.wdata);
    chk("i_rdata", i_rdata, m_i_rd);
    chk("d_rdata", d_rdata, m_d_rd);
    if (mem_write_en) begin
      we_cnt++;
      we_addr_seen  = mem_addr;
      we_wdata_seen = mem_wdata;
    end
    if ((q.size() > 0) && (q[0].done <= cyc)) void'(q.pop_front());
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          got, g1, g2, prev_done, c0, n;
    logic [31:0] saved;
    rst_b = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req1 = 1'b0; i_addr1 = '0; d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
    mem_const_en = 1'b0; mem_const = '0;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);

    // Fetch-only read with a constant memory word
    mem_const_en = 1'b1; mem_const = 32'hDEAD_BEEF; we_cnt = 0;
    i_req = 1'b1; i_addr = 32'h100;
    wait_done(0, got);
    chk("fetch_latency", 32'(cyc - m_last_g), 32'(LAT + 1));
    chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("fetch_no_write", 32'(we_cnt), 32'd0);
    i_req = 1'b0; mem_const_en = 1'b0;

    // Data read, then data write that must leave d_rdata alone
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    wait_done(1, got);
    saved = exp_rd(32'h20, cyc - 1);
    d_req = 1'b0;
    tick();
    we_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    wait_done(1, got);
    chk("write_strobe_cycles", 32'(we_cnt), 32'd1);
    chk("write_addr", we_addr_seen, 32'h40);
    chk("write_wdata", we_wdata_seen, 32'h1234_5678);
    chk("write_keeps_rdata", d_rdata, saved);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Held request: new transaction granted in the IDLE cycle right after RESP
    d_req = 1'b1; d_addr = 32'h60;
    wait_done(1, got);
    prev_done = cyc;
    d_addr = 32'h80;
    wait_done(1, got);
    chk("held_grant_cycle", 32'(m_last_g), 32'(prev_done + 1));
    chk("held_latency", 32'(cyc - m_last_g), 32'(LAT + 1));
    chk("held_mem_addr", mem_addr, 32'h80);
    d_req = 1'b0;
    tick();

    // Reset during the second ACCESS cycle of a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h33C;
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_d_done", {31'b0, d_done}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    chk("abort_i_rdata", i_rdata, 32'd0);
    rst_b = 1'b1; d_req = 1'b0;
    repeat (LAT + 3) tick();

    // Simultaneous requests held for two transactions
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    wait_done(2, g1);
    wait_done(2, g2);
    i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("sim_first_port", 32'(g1), 32'd1);
    chk("sim_second_port", 32'(g2), 32'd0);
`else
    chk("sim_first_port", 32'(g1), 32'd1);
    chk("sim_second_port", 32'(g2), 32'd1);
`endif
    repeat (LAT + 3) tick();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      if (i_done) begin
        i_req = ($urandom_range(3) != 0); i_addr = $urandom;
      end else if (!i_req) begin
        i_req = ($urandom_range(2) == 0); i_addr = $urandom;
      end else begin
        i_addr = $urandom;
      end
      if (d_done) begin
        d_req = ($urandom_range(3) != 0);
      end else if (!d_req) begin
        d_req = ($urandom_range(2) == 0);
      end
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = $urandom_range(1);
      rst_b   = ($urandom_range(299) != 0);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; rst_b = 1'b1;
    repeat (LAT + 4) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    // MEM_LATENCY=1 instance: data read done two cycles after sample
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h44;
    c0 = cyc;
    n  = 0;
    do begin
      tick();
      n++;
    end while (!d_done1 && (n < 20));
    chk("lat1_done_cycles", 32'(cyc - c0), 32'd2);
    chk("lat1_rdata", d_rdata1, 32'hCAFE_0001);
    chk("lat1_i_done", {31'b0, i_done1}, 32'd0);
    chk("lat1_busy", {31'b0, busy1}, 32'd1);
    chk("lat1_mem_addr", mem_addr1, 32'h44);
    chk("lat1_mem_wdata", mem_wdata1, 32'd0);
    chk("lat1_write_en", {31'b0, mem_write_en1}, 32'd0);
    chk("lat1_i_rdata", i_rdata1, 32'd0);
    d_req1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
